rv_mc_control_fsm: RTL

// Multicycle control unit directly upstream of the ALU: sequences every RV32I instruction

---
 rtl/rv_mc_pkg.sv | 52 +++++
 rtl/rv_alu_decoder.sv | 46 ++++
 rtl/rv_mc_control_fsm.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU control,
// datapath mux selects and opcodes.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StBranch, StJal, StJalrAdr, StJalrJmp, StLui, StAuipc, StTrap
    } state_t;

    typedef enum logic [1:0] {AluOpAdd, AluOpBranch, AluOpFunct} alu_op_t;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op class and the instruction funct bits.
module rv_alu_decoder
    import rv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alu_control,
    output logic       branch_illegal
);

    always_comb begin
        alu_control    = AluAdd;
        branch_illegal = 1'b0;
        unique case (alu_op)
            AluOpAdd: alu_control = AluAdd;
            AluOpBranch: begin
                unique case (funct3)
                    3'b000, 3'b001: alu_control = AluSub;
                    3'b100, 3'b101: alu_control = AluSlt;
                    3'b110, 3'b111: alu_control = AluSltu;
                    default: begin
                        alu_control    = AluSub;
                        branch_illegal = 1'b1;
                    end
                endcase
            end
            AluOpFunct: begin
                unique case (funct3)
                    // funct7_5 on I-type ADDI is part of the immediate, never SUB
                    3'b000:  alu_control = (is_rtype && funct7_5) ? AluSub : AluAdd;
                    3'b001:  alu_control = AluSll;
                    3'b010:  alu_control = AluSlt;
                    3'b011:  alu_control = AluSltu;
                    3'b100:  alu_control = AluXor;
                    3'b101:  alu_control = funct7_5 ? AluSra : AluSrl;
                    3'b110:  alu_control = AluOr;
                    default: alu_control = AluAnd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/rv_mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback and drives the
// datapath selects, write enables and memory handshake.
module rv_mc_control_fsm
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic [3:0] alu_control,
    output logic       illegal_instr,
    output logic       instr_retire
);

    state_t  state_q, state_d;
    logic    illegal_q;
    alu_op_t alu_op;
    logic    is_rtype;
    logic    branch_illegal;
    logic    branch_taken;
    logic    mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw, retire_raw;

    rv_alu_decoder u_alu_decoder (
        .alu_op         (alu_op),
        .funct3         (funct3),
        .funct7_5       (funct7_5),
        .is_rtype       (is_rtype),
        .alu_control    (alu_control),
        .branch_illegal (branch_illegal)
    );

    // beq/bge/bgeu take on zero; bne/blt/bltu (funct3[2]^funct3[0] set) take on non-zero
    assign branch_taken = alu_zero ^ (funct3[2] ^ funct3[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        imm_src       = ImmI;
        result_src    = ResAluOut;
        alu_op        = AluOpAdd;
        is_rtype      = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req_raw = 1'b1;
                alu_src_b   = SrcBFour;
                result_src  = ResAluResult;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = (opcode == OpJal) ? ImmJ : ImmB;
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrAdr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                imm_src   = (opcode == OpStore) ? ImmS : ImmI;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src    = ResReadData;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (mem_ready) begin
                    retire_raw = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpFunct;
                is_rtype  = 1'b1;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpBranch;
                if (branch_illegal) begin
                    state_d = StTrap;
                end else begin
                    pc_write_raw = branch_taken;
                    retire_raw   = 1'b1;
                    state_d      = StFetch;
                end
            end
            StJal: begin
                alu_src_a    = SrcAOldPc;
                alu_src_b    = SrcBFour;
                pc_write_raw = 1'b1;
                state_d      = StAluWb;
            end
            StJalrAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = StJalrJmp;
            end
            StJalrJmp: begin
                alu_src_a    = SrcAOldPc;
                alu_src_b    = SrcBFour;
                pc_write_raw = 1'b1;
                state_d      = StAluWb;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                imm_src   = ImmU;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = ImmU;
                state_d   = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Strobes are gated by rst_n directly so an asserted reset kills them within the cycle
    assign mem_req       = mem_req_raw & rst_n;
    assign mem_write     = mem_write_raw & rst_n;
    assign ir_write      = ir_write_raw & rst_n;
    assign pc_write      = pc_write_raw & rst_n;
    assign reg_write     = reg_write_raw & rst_n;
    assign instr_retire  = retire_raw & rst_n;
    assign illegal_instr = illegal_q;

endmodule
